width_downsizer: RTL

- Converts a wide valid/ready stream into a narrow one by serializing each wide word into RATIO = IN_W/OUT_W narrow beats.
- It is the wide-producer-to-narrow-consumer counterpart of zero-pad widening: it is inserted where a wide output feeds a narrow input.
- Can alternatively operate in truncate mode, forwarding only the low OUT_W bits of each word.
- Sits between instance ports in generated top levels as a registered adapter.

---
 rtl/width_downsizer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/width_downsizer.sv
// -----------------------------------------------------------------------------
// width_downsizer
//
// Registered adapter that takes a wide word and sends it out as RATIO
// narrow beats, where RATIO = IN_W / OUT_W. It is used where a wide producer
// drives a narrow consumer. With TRUNCATE=1 it sends one beat per word instead,
// holding only the low OUT_W bits of the word.
//
// Handshake rules (valid/ready):
//   - A transfer happens on a rising edge where valid and ready are both 1.
//   - out_valid comes from a register only. It never depends combinationally
//     on out_ready.
//   - While out_valid=1 and out_ready=0, data_out and out_last hold steady.
//   - in_ready may depend on out_ready during the final beat. This lets a new
//     word load on the same edge that the final beat leaves.
//   - A word offered while in_ready=0 is not sampled. The source must hold it.
//
// Parameters:
//   IN_W      - wide input width; must be an integer multiple of OUT_W
//   OUT_W     - narrow output width; IN_W / OUT_W must be at least 2
//   LSB_FIRST - 1: beat 0 is bits [OUT_W-1:0]; 0: beat 0 is the top slice
//   TRUNCATE  - 1: one beat per word carrying data_in[OUT_W-1:0]
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   wide word available
//   in_ready   out  adapter accepts a wide word this cycle
//   data_in    in   wide word [IN_W-1:0]
//   in_last    in   word is the final word of a packet
//   out_valid  out  narrow beat available
//   out_ready  in   consumer accepts the beat
//   data_out   out  narrow beat [OUT_W-1:0]
//   out_last   out  final beat of a word that was captured with in_last=1
//   busy       out  holding register occupied (same as out_valid)
//   fsm_state  out  current FSM state (0 = IDLE, 1 = SEND), for debug
// -----------------------------------------------------------------------------
module width_downsizer #(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 8,
    parameter int LSB_FIRST = 1,
    parameter int TRUNCATE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  data_in,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] data_out,
    output logic             out_last,
    output logic             busy,
    output logic             fsm_state
);

    localparam int RATIO = IN_W / OUT_W;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

    // Stop elaboration when the widths cannot be split into whole beats.
    generate
        if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : g_param_check
            $error("width_downsizer: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;

    logic               final_beat;
    logic               in_xfer;
    logic               out_xfer;
    logic [OUT_W-1:0]   slice;

    // In truncate mode every beat is the final beat of its word.
    assign final_beat = (TRUNCATE != 0) ? 1'b1 : (cnt_q == CNT_MAX);

    assign out_valid  = (state_q == SEND);
    assign busy       = out_valid;
    assign fsm_state  = state_q;

    // Accept a word when empty. During the final beat, also accept one if that
    // beat leaves on this edge. This is what removes the bubble between words.
    assign in_ready   = (state_q == IDLE) ||
                        ((state_q == SEND) && final_beat && out_ready);

    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;

    // Choose the slice for the current beat. The loop uses constant part
    // selects only, so each slice is a fixed wire into the mux.
    always_comb begin
        slice = '0;
        if (TRUNCATE != 0) begin
            slice = hold_q[OUT_W-1:0];
        end else begin
            for (int k = 0; k < RATIO; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    if (LSB_FIRST != 0) begin
                        slice = hold_q[k*OUT_W +: OUT_W];
                    end else begin
                        slice = hold_q[(RATIO-1-k)*OUT_W +: OUT_W];
                    end
                end
            end
        end
    end

    assign data_out = out_valid ? slice : '0;
    assign out_last = out_valid && final_beat && last_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        unique case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    hold_d  = data_in;
                    last_d  = in_last;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end

            SEND: begin
                if (out_xfer) begin
                    if (final_beat) begin
                        if (in_xfer) begin
                            // The final beat leaves as the next word loads: keep streaming.
                            hold_d  = data_in;
                            last_d  = in_last;
                            cnt_d   = '0;
                            state_d = SEND;
                        end else begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers. Reset takes priority over any handshake on the same
    // edge and drops a word that is only partly sent.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

endmodule
